// File: rtl/shift_out_pkg.sv
// Shared types and constants for the 4-bit serial transmitter.
// Frame: start bit, four data bits LSB first, stop bit.
package shift_out_pkg;

    localparam int DATA_W     = 4;
    localparam int FRAME_BITS = 6;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

endpackage

// File: rtl/shift_out_4_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and ticks on the last count.
// Held at zero while i_clr is high so every bit starts on a clean count.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW =
        (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign o_tick = (cnt == LAST) && !i_clr;

    // Free-running count within a bit, wrapping at each bit boundary.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_clr || o_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/shift_out_4.sv
// 4-bit parallel-in serial-out transmitter with valid/ready intake.
// All outputs come straight from flops, computed from the next state.
module shift_out_4
    import shift_out_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_d,
    output logic              o_ready,
    output logic              o_sd,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [1:0] LAST_BIT = 2'(DATA_W - 1);

    state_t            state;
    state_t            state_n;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_n;
    logic [1:0]        idx;
    logic [1:0]        idx_n;
    logic              sd_n;
    logic              done_n;
    logic              tick;
    logic              clr;

    assign clr = (state == IDLE);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_clr  (clr),
        .o_tick (tick)
    );

    // Next-state, next shift contents and next line level.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        idx_n   = idx;
        sd_n    = o_sd;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                sd_n = 1'b1;
                if (i_valid) begin
                    state_n = START;
                    shreg_n = i_d;
                    idx_n   = 2'd0;
                    sd_n    = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    sd_n    = shreg[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_n = {1'b0, shreg[DATA_W-1:1]};
                    if (idx == LAST_BIT) begin
                        state_n = STOP;
                        sd_n    = 1'b1;
                    end else begin
                        idx_n = idx + 2'd1;
                        sd_n  = shreg[1];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    sd_n    = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                sd_n    = 1'b1;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            idx     <= 2'd0;
            o_sd    <= 1'b1;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            idx     <= idx_n;
            o_sd    <= sd_n;
            o_ready <= (state_n == IDLE);
            o_busy  <= (state_n != IDLE);
            o_done  <= done_n;
        end
    end

endmodule

// File: tb/tb_shift_out_4.sv
// Bench for shift_out_4: CLKS_PER_BIT=4 and =1 instances against
// a frame-position model, plus literal waveform expectations.
module tb_shift_out_4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v4 = 1'b0;
    logic       v1 = 1'b0;
    logic [3:0] d4 = 4'd0;
    logic [3:0] d1 = 4'd0;
    logic       sd4, rdy4, bsy4, done4;
    logic       sd1, rdy1, bsy1, done1;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_out_4 #(.CLKS_PER_BIT(4)) dut4 (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_valid(v4),
        .i_d    (d4),
        .o_ready(rdy4),
        .o_sd   (sd4),
        .o_busy (bsy4),
        .o_done (done4)
    );

    shift_out_4 #(.CLKS_PER_BIT(1)) dut1 (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_valid(v1),
        .i_d    (d1),
        .o_ready(rdy1),
        .o_sd   (sd1),
        .o_busy (bsy1),
        .o_done (done1)
    );

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    // Model: position in frame in clock cycles, -1 when idle.
    int         pos4 = -1;
    int         pos1 = -1;
    logic [3:0] w4 = 4'd0;
    logic [3:0] w1 = 4'd0;
    logic       md4 = 1'b0;
    logic       md1 = 1'b0;

    // Expected {sd, ready, busy, done} from frame position.
    function automatic logic [3:0] exp_out(int pos,
                                           logic [3:0] w,
                                           logic dn,
                                           int cpb);
        int   b;
        logic s;
        if (pos < 0) return {1'b1, 1'b1, 1'b0, dn};
        b = pos / cpb;
        if (b == 0) s = 1'b0;
        else if (b == 5) s = 1'b1;
        else s = w[b-1];
        return {s, 1'b0, 1'b1, 1'b0};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos4 <= -1;
            md4  <= 1'b0;
        end else begin
            md4 <= 1'b0;
            if (pos4 < 0) begin
                if (v4) begin
                    pos4 <= 0;
                    w4   <= d4;
                end
            end else if (pos4 == 6 * 4 - 1) begin
                pos4 <= -1;
                md4  <= 1'b1;
            end else begin
                pos4 <= pos4 + 1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos1 <= -1;
            md1  <= 1'b0;
        end else begin
            md1 <= 1'b0;
            if (pos1 < 0) begin
                if (v1) begin
                    pos1 <= 0;
                    w1   <= d1;
                end
            end else if (pos1 == 6 * 1 - 1) begin
                pos1 <= -1;
                md1  <= 1'b1;
            end else begin
                pos1 <= pos1 + 1;
            end
        end
    end

    // Compare every cycle against the model.
    always @(negedge clk) begin
        chk("cmp4", {60'd0, sd4, rdy4, bsy4, done4},
            {60'd0, exp_out(pos4, w4, md4, 4)});
        chk("cmp1", {60'd0, sd1, rdy1, bsy1, done1},
            {60'd0, exp_out(pos1, w1, md1, 1)});
    end

    task automatic capture(input int sel, input int n,
                           output logic [63:0] s,
                           output logic [63:0] dn,
                           output logic [63:0] r);
        s  = '0;
        dn = '0;
        r  = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s  = {s[62:0], (sel == 1) ? sd1 : sd4};
            dn = {dn[62:0], (sel == 1) ? done1 : done4};
            r  = {r[62:0], (sel == 1) ? rdy1 : rdy4};
        end
    endtask

    task automatic wait_idle(input int sel);
        int n = 0;
        while (!((sel == 1) ? rdy1 : rdy4) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", {63'd0, (sel == 1) ? rdy1 : rdy4}, 64'd1);
    endtask

    task automatic send(input int sel, input logic [3:0] w);
        @(posedge clk);
        #1;
        if (sel == 1) begin
            v1 = 1'b1;
            d1 = w;
        end else begin
            v4 = 1'b1;
            d4 = w;
        end
        @(posedge clk);
        #1;
        v1 = 1'b0;
        v4 = 1'b0;
    endtask

    initial begin
        logic [63:0] s, dn, r;
        logic [63:0] s2, dn2, r2;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", {60'd0, sd4, rdy4, bsy4, done4},
            64'b1100);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1010 at 4 clocks per bit
        wait_idle(0);
        send(0, 4'b1010);
        capture(0, 25, s, dn, r);
        chk("f1010_sd", {40'd0, s[24:1]}, 64'h00F0FF);
        chk("f1010_done25", {63'd0, dn[0]}, 64'd1);
        chk("f1010_done24", {63'd0, dn[1]}, 64'd0);
        chk("f1010_rdy25", {63'd0, r[0]}, 64'd1);

        // back-to-back with valid held high
        wait_idle(0);
        @(posedge clk);
        #1;
        v4 = 1'b1;
        d4 = 4'b0001;
        @(posedge clk);
        #1 d4 = 4'b1111;
        capture(0, 26, s, dn, r);
        v4 = 1'b0;
        capture(0, 24, s2, dn2, r2);
        chk("b2b_f1_sd", {40'd0, s[25:2]}, 64'h0F000F);
        chk("b2b_done25", {63'd0, dn[1]}, 64'd1);
        chk("b2b_rdy25", {63'd0, r[1]}, 64'd1);
        chk("b2b_start26", {63'd0, s[0]}, 64'd0);
        chk("b2b_f2_sd", {41'd0, s2[23:1]}, 64'h0FFFFF);
        chk("b2b_done50", {63'd0, dn2[0]}, 64'd1);

        // data input churns mid-frame
        wait_idle(0);
        send(0, 4'b0110);
        s  = '0;
        dn = '0;
        r  = '0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            s  = {s[62:0], sd4};
            dn = {dn[62:0], done4};
            r  = {r[62:0], rdy4};
            d4 = 4'($urandom);
            v4 = (i <= 23) ? 1'($urandom) : 1'b0;
        end
        chk("f0110_sd", {40'd0, s[24:1]}, 64'h00FF0F);
        chk("f0110_rdy", {40'd0, r[24:1]}, 64'd0);
        chk("f0110_done", {63'd0, dn[0]}, 64'd1);

        // reset in the middle of the data bits
        wait_idle(0);
        send(0, 4'b1100);
        repeat (8) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_vals", {61'd0, sd4, rdy4, bsy4}, 64'b110);
        v4 = 1'b1;
        d4 = 4'b1001;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 v4 = 1'b0;
        capture(0, 25, s, dn, r);
        chk("post_rst_sd", {40'd0, s[24:1]}, 64'h0F00FF);
        chk("post_rst_nodone", {40'd0, dn[24:1]}, 64'd0);
        chk("post_rst_done", {63'd0, dn[0]}, 64'd1);

        // one clock per bit
        wait_idle(1);
        send(1, 4'b0011);
        capture(1, 7, s, dn, r);
        chk("cpb1_sd", {58'd0, s[6:1]}, 64'b011001);
        chk("cpb1_done7", {63'd0, dn[0]}, 64'd1);
        chk("cpb1_done6", {63'd0, dn[1]}, 64'd0);

        // idle hold
        wait_idle(0);
        capture(0, 50, s, dn, r);
        chk("idle_sd", s, 64'h3FFFFFFFFFFFF);
        chk("idle_rdy", r, 64'h3FFFFFFFFFFFF);
        chk("idle_done", dn, 64'd0);

        // random traffic on both instances
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            v4 = ($urandom_range(0, 3) == 0);
            d4 = 4'($urandom);
            v1 = ($urandom_range(0, 2) == 0);
            d1 = 4'($urandom);
        end
        v4 = 1'b0;
        v1 = 1'b0;
        repeat (40) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
